// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: arbiter FSM state type, read-latency ceiling and latency-counter width
package cpu_mem_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, RESP} state_t;
  localparam int RD_LAT_MAX = 4;
  localparam int CNT_W = $clog2(RD_LAT_MAX + 1);
endpackage

// File: rtl/rr_grant.sv
// rr_grant: one-hot gnt from req; mode=1 round-robin from last+1, mode=0 lowest index wins
module rr_grant #(
  parameter int NCH = 3,
  parameter int IW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req,
  input  logic           mode,
  input  logic [IW-1:0]  last,
  output logic [NCH-1:0] gnt
);
  always_comb begin
    gnt = '0;
    for (int k = NCH - 1; k >= 0; k--)
      for (int i = 0; i < NCH; i++)
        if (req[i] && i == (mode ? (int'(last) + 1 + k) % NCH : k)) gnt = NCH'(1) << i;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: NCH requesters (req_*) share one RAM port (ram_*); completions on rsp_*, busy when not IDLE
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int NCH = 3,
  parameter int DW = 32,
  parameter int RAM_AW = 12,
  parameter int RD_LAT = 1,
  parameter int RR_MODE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    req_valid,
  input  logic [NCH-1:0]    req_write,
  input  logic [NCH*32-1:0] req_addr,
  input  logic [NCH*DW-1:0] req_wdata,
  output logic [NCH-1:0]    req_ready,
  output logic [NCH-1:0]    rsp_valid,
  output logic [DW-1:0]     rsp_rdata,
  output logic              rsp_err,
  output logic              ram_we,
  output logic              ram_re,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DW-1:0]     ram_wdata,
  input  logic [DW-1:0]     ram_rdata,
  output logic              busy
);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  state_t            state_q;
  logic [IW-1:0]     last_q, ch_q, sel_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [RAM_AW-1:0] addr_q;
  logic [DW-1:0]     wdata_q, rdata_q, wd_d;
  logic [NCH-1:0]    rsp_valid_q, gnt;
  logic              err_q, we_q, re_q, wr_d, oor_d, any_d;
  logic [31:0]       a_d;
  rr_grant #(.NCH(NCH), .IW(IW)) u_grant (
    .req (req_valid),
    .mode(RR_MODE != 0),
    .last(last_q),
    .gnt (gnt)
  );
  always_comb begin
    sel_d = '0;
    a_d = '0;
    wd_d = '0;
    wr_d = 1'b0;
    for (int i = 0; i < NCH; i++)
      if (gnt[i]) begin
        sel_d = IW'(i);
        a_d = req_addr[32*i +: 32];
        wd_d = req_wdata[DW*i +: DW];
        wr_d = req_write[i];
      end
    oor_d = |a_d[31:RAM_AW];
    any_d = state_q == IDLE && |gnt && !reset;
  end
  assign req_ready = any_d ? gnt : '0;
  assign rsp_err = err_q | (any_d & oor_d);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign ram_we = we_q;
  assign ram_re = re_q;
  assign ram_addr = addr_q;
  assign ram_wdata = wdata_q;
  assign busy = state_q != IDLE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q <= IW'(NCH - 1);
      ch_q <= '0;
      cnt_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rsp_valid_q <= '0;
      err_q <= 1'b0;
      we_q <= 1'b0;
      re_q <= 1'b0;
    end else begin
      we_q <= 1'b0;
      re_q <= 1'b0;
      rsp_valid_q <= '0;
      err_q <= 1'b0;
      if (any_d) begin
        last_q <= sel_d;
        ch_q <= sel_d;
        addr_q <= a_d[RAM_AW-1:0];
        wdata_q <= wd_d;
        cnt_q <= '0;
        if (oor_d && !wr_d) begin
          state_q <= RESP;
          rsp_valid_q <= gnt;
          rdata_q <= '0;
          err_q <= 1'b1;
        end else if (!oor_d) begin
          state_q <= wr_d ? WRITE : READ_WAIT;
          we_q <= wr_d;
          re_q <= !wr_d;
        end
      end else if (state_q == READ_WAIT) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CNT_W'(RD_LAT)) begin
          state_q <= RESP;
          rsp_valid_q <= NCH'(1) << ch_q;
          rdata_q <= ram_rdata;
        end
      end else if (state_q != IDLE) begin
        state_q <= IDLE;
        rdata_q <= '0;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench over five arbiter builds (RD_LAT 1..4 round-robin, RD_LAT 1 fixed)
module tb_mem_port_arbiter;
  localparam int N = 5;
  typedef struct packed {
    logic [2:0]  inst;
    logic [1:0]  kind;
    logic [1:0]  ch;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    logic [7:0]  dly;
  } ev_t;
  ev_t q[$];
  int errors = 0, checks = 0, cyc = 0;
  int last_rdy[N];
  logic clk = 0, rst = 1;
  logic [2:0]  rv[N], rw[N], rdy[N], rsv[N];
  logic [95:0] ra[N], rd[N];
  logic [31:0] rdat[N], mwd[N], mrd[N];
  logic [11:0] ma[N];
  logic        err[N], we[N], re[N], bsy[N];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int lat_of(int i);
    return i == 4 ? 1 : i + 1;
  endfunction
  generate
    for (genvar g = 0; g < N; g++) begin : gd
      logic [31:0] mem [0:4095];
      logic [31:0] pipe [0:3];
      mem_port_arbiter #(.RD_LAT(g == 4 ? 1 : g + 1), .RR_MODE(g == 4 ? 0 : 1)) dut (
        .clk(clk), .reset(rst), .req_valid(rv[g]), .req_write(rw[g]), .req_addr(ra[g]),
        .req_wdata(rd[g]), .req_ready(rdy[g]), .rsp_valid(rsv[g]), .rsp_rdata(rdat[g]),
        .rsp_err(err[g]), .ram_we(we[g]), .ram_re(re[g]), .ram_addr(ma[g]),
        .ram_wdata(mwd[g]), .ram_rdata(mrd[g]), .busy(bsy[g])
      );
      assign mrd[g] = pipe[(g == 4 ? 1 : g + 1) - 1];
      always @(posedge clk) begin
        if (rst) mem[16] <= 32'hDEADBEEF;
        else if (we[g]) mem[ma[g]] <= mwd[g];
        pipe[0] <= re[g] ? mem[ma[g]] : 32'hBAD0BAD0;
        for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
      end
    end
  endgenerate
  function automatic logic [1:0] oh2i(logic [2:0] v);
    return v[2] ? 2'd2 : v[1] ? 2'd1 : 2'd0;
  endfunction
  function automatic void push(int i, int k, int ch, logic [31:0] a, logic [31:0] d, logic e, int dly);
    q.push_back('{inst: 3'(i), kind: 2'(k), ch: 2'(ch), addr: a, data: d, err: e, dly: 8'(dly)});
  endfunction
  function automatic void exp_wr(int i, int ch, logic [31:0] a, logic [31:0] d);
    push(i, 0, ch, 0, 0, 0, 0);
    push(i, 1, 0, a, d, 0, 1);
  endfunction
  function automatic void exp_rd(int i, int ch, logic [31:0] a, logic [31:0] d);
    push(i, 0, ch, 0, 0, 0, 0);
    push(i, 2, 0, a, 0, 0, 1);
    push(i, 3, ch, 0, d, 0, lat_of(i) + 2);
  endfunction
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      ev_t ge, ex;
      logic hv;
      checks++;
      if (!$onehot0(rdy[i]) || !$onehot0(rsv[i]) || (we[i] && re[i])) begin
        errors++;
        $display("FAIL exclusive inst%0d: ready=%b rsp_valid=%b we=%b re=%b, want one-hot and no we&re", i, rdy[i], rsv[i], we[i], re[i]);
      end
      hv = 1'b1;
      ge = '{inst: 3'(i), kind: 2'd0, ch: 2'd0, addr: 32'd0, data: 32'd0, err: 1'b0, dly: 8'd0};
      if (rdy[i] != 0) begin
        ge.ch = oh2i(rdy[i]);
        ge.err = err[i];
        last_rdy[i] = cyc;
      end else if (we[i]) begin
        ge.kind = 2'd1;
        ge.addr = {20'd0, ma[i]};
        ge.data = mwd[i];
        ge.dly = 8'(cyc - last_rdy[i]);
      end else if (re[i]) begin
        ge.kind = 2'd2;
        ge.addr = {20'd0, ma[i]};
        ge.dly = 8'(cyc - last_rdy[i]);
      end else if (rsv[i] != 0) begin
        ge.kind = 2'd3;
        ge.ch = oh2i(rsv[i]);
        ge.data = rdat[i];
        ge.err = err[i];
        ge.dly = 8'(cyc - last_rdy[i]);
      end else hv = 1'b0;
      if (hv) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected inst%0d: kind=%0d ch=%0d addr=%h data=%h err=%0d, want no event", i, ge.kind, ge.ch, ge.addr, ge.data, ge.err);
        end else begin
          ex = q.pop_front();
          if (ex != ge) begin
            errors++;
            $display("FAIL event: got inst%0d kind=%0d ch=%0d addr=%h data=%h err=%0d dly=%0d, want inst%0d kind=%0d ch=%0d addr=%h data=%h err=%0d dly=%0d",
                     ge.inst, ge.kind, ge.ch, ge.addr, ge.data, ge.err, ge.dly, ex.inst, ex.kind, ex.ch, ex.addr, ex.data, ex.err, ex.dly);
          end
        end
      end
    end
  end
  task automatic wait_idle(input int i);
    int n = 0;
    while (bsy[i] && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bsy[i]) begin
      errors++;
      $display("FAIL idle_timeout inst%0d: busy=1, want 0 within 40 cycles", i);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic do_req(input int i, input int ch, input logic wr, input logic [31:0] a, input logic [31:0] d);
    logic got = 1'b0;
    rv[i][ch] = 1'b1;
    rw[i][ch] = wr;
    ra[i][32*ch +: 32] = a;
    rd[i][32*ch +: 32] = d;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      got = rdy[i][ch];
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL grant_timeout inst%0d ch%0d: ready=0, want 1 within 50 cycles", i, ch);
    end
    @(posedge clk);
    #1;
    rv[i][ch] = 1'b0;
    wait_idle(i);
  endtask
  task automatic burst(input int i);
    for (int c = 0; c < 3; c++) begin
      ra[i][32*c +: 32] = 32'h100 + c;
      rd[i][32*c +: 32] = 32'hC0 + c;
    end
    rw[i] = 3'b111;
    rv[i] = 3'b111;
    repeat (11) @(posedge clk);
    #1;
    rv[i] = 3'b000;
    wait_idle(i);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < N; i++) begin
      rv[i] = 0; rw[i] = 0; ra[i] = 0; rd[i] = 0; last_rdy[i] = 0;
    end
    @(posedge clk);
    #1;
    rv[0] = 3'b111;
    #2;
    for (int i = 0; i < N; i++) begin
      checks++;
      if ({rdy[i], rsv[i], rdat[i], err[i], we[i], re[i], ma[i], mwd[i], bsy[i]} != 0) begin
        errors++;
        $display("FAIL reset_outputs inst%0d: ready=%b rsp_valid=%b rdata=%h err=%b we=%b re=%b addr=%h wdata=%h busy=%b, want all 0",
                 i, rdy[i], rsv[i], rdat[i], err[i], we[i], re[i], ma[i], mwd[i], bsy[i]);
      end
    end
    rv[0] = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk);
    #1;
    exp_rd(0, 0, 32'h10, 32'hDEADBEEF);
    do_req(0, 0, 1'b0, 32'h10, 32'h0);
    exp_wr(0, 1, 32'h20, 32'h55AA);
    do_req(0, 1, 1'b1, 32'h20, 32'h55AA);
    exp_rd(0, 1, 32'h20, 32'h55AA);
    do_req(0, 1, 1'b0, 32'h20, 32'h0);
    push(0, 0, 2, 0, 0, 1, 0);
    push(0, 3, 2, 0, 0, 1, 1);
    do_req(0, 2, 1'b0, 32'h1000, 32'h0);
    for (int k = 0; k < 6; k++) exp_wr(0, k % 3, 32'h100 + k % 3, 32'hC0 + k % 3);
    burst(0);
    push(0, 0, 0, 0, 0, 1, 0);
    do_req(0, 0, 1'b1, 32'h2000, 32'h77);
    for (int k = 0; k < 6; k++) exp_wr(4, 0, 32'h100, 32'hC0);
    burst(4);
    for (int i = 1; i < 4; i++) begin
      exp_rd(i, 0, 32'h10, 32'hDEADBEEF);
      do_req(i, 0, 1'b0, 32'h10, 32'h0);
    end
    exp_wr(2, 0, 32'h30, 32'h1234);
    do_req(2, 0, 1'b1, 32'h30, 32'h1234);
    push(2, 0, 1, 0, 0, 0, 0);
    push(2, 2, 0, 32'h10, 0, 0, 1);
    rv[2][1] = 1'b1;
    rw[2][1] = 1'b0;
    ra[2][63:32] = 32'h10;
    @(negedge clk);
    @(posedge clk);
    #1;
    rv[2][1] = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bsy[2] !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_read_wait: busy=%b, want 1", bsy[2]);
    end
    rst = 1;
    #1;
    checks++;
    if (bsy[2] !== 1'b0 || rsv[2] !== 3'b000) begin
      errors++;
      $display("FAIL reset_abort: busy=%b rsp_valid=%b, want 0 and 000", bsy[2], rsv[2]);
    end
    @(posedge clk);
    #1;
    rst = 0;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL abort_pending: %0d expected events left, want 0", q.size());
    end
    exp_wr(2, 0, 32'h40, 32'hA);
    ra[2] = {32'h44, 32'h0, 32'h40};
    rd[2] = {32'hB, 32'h0, 32'hA};
    rw[2] = 3'b101;
    rv[2] = 3'b101;
    @(posedge clk);
    #1;
    rv[2] = 3'b000;
    wait_idle(2);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL final_pending: %0d expected events never seen, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
